// File: rtl/fetch.sv
// fetch: instruction fetch stage feeding decode through a small instruction queue.
// Build option FETCH_PREFETCH_EN: defined -> 2-entry queue, so fetch can run ahead
// while decode stalls; undefined -> 1 entry, next request only after a pop.
// The clock port is named req; all state updates on its rising edge.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        req,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  logic [31:0] fetch_pc, fetch_pc_next;
  logic        discard, discard_next;
  logic        req_next;
  logic [31:0] addr_next;
  logic [1:0]  count, count_next, count_after_pop;
  logic [31:0] head_instr, head_instr_next;
  logic [31:0] head_pc, head_pc_next;
`ifdef FETCH_PREFETCH_EN
  logic [31:0] tail_instr, tail_instr_next;
  logic [31:0] tail_pc, tail_pc_next;
`endif
  logic        ack_take, push, pop, issue;

  // Queue head presented to decode; NOP/0 when nothing is held
  always_comb begin
    valid_out = (count != '0);
    instr_out = valid_out ? head_instr : NOP;
    pc_out    = valid_out ? head_pc : '0;
  end

  // Next-state: queue push/pop, request issue and redirect handling
  always_comb begin
    ack_take        = imem_req_out & imem_ack_in;
    pop             = valid_out & ~stall_in;
    push            = ack_take & ~discard;
    count_after_pop = count - {1'b0, pop};
    issue           = 1'b0;
    fetch_pc_next   = fetch_pc;
    req_next        = imem_req_out;
    addr_next       = imem_addr_out;
    discard_next    = discard;
    count_next      = count;
    head_instr_next = head_instr;
    head_pc_next    = head_pc;
`ifdef FETCH_PREFETCH_EN
    tail_instr_next = tail_instr;
    tail_pc_next    = tail_pc;
`endif
    if (redirect_in) begin
      // An un-acked request stays on the bus; its data is dropped when it returns.
      // An ack on this same edge completes the request and is dropped here.
      count_next    = '0;
      fetch_pc_next = redirect_pc_in & 32'hFFFF_FFFC;
      req_next      = imem_req_out & ~imem_ack_in;
      discard_next  = imem_req_out & ~imem_ack_in;
    end else begin
      if (ack_take) discard_next = 1'b0;
`ifdef FETCH_PREFETCH_EN
      if (pop) begin
        head_instr_next = tail_instr;
        head_pc_next    = tail_pc;
      end
      if (push) begin
        if (count_after_pop == '0) begin
          head_instr_next = imem_data_in;
          head_pc_next    = imem_addr_out;
        end else begin
          tail_instr_next = imem_data_in;
          tail_pc_next    = imem_addr_out;
        end
      end
`else
      if (push) begin
        head_instr_next = imem_data_in;
        head_pc_next    = imem_addr_out;
      end
`endif
      count_next = count_after_pop + {1'b0, push};
      // At most one request in flight, and only while a queue slot is reserved for it
      issue = (~imem_req_out | ack_take) & (count_next < DEPTH);
      if (issue) begin
        req_next      = 1'b1;
        addr_next     = fetch_pc;
        fetch_pc_next = fetch_pc + 32'd4;
      end else if (ack_take) begin
        req_next = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge req) begin
    if (rst) begin
      fetch_pc      <= RESET_PC;
      discard       <= 1'b0;
      imem_req_out  <= 1'b0;
      imem_addr_out <= '0;
      count         <= '0;
      head_instr    <= '0;
      head_pc       <= '0;
`ifdef FETCH_PREFETCH_EN
      tail_instr    <= '0;
      tail_pc       <= '0;
`endif
    end else begin
      fetch_pc      <= fetch_pc_next;
      discard       <= discard_next;
      imem_req_out  <= req_next;
      imem_addr_out <= addr_next;
      count         <= count_next;
      head_instr    <= head_instr_next;
      head_pc       <= head_pc_next;
`ifdef FETCH_PREFETCH_EN
      tail_instr    <= tail_instr_next;
      tail_pc       <= tail_pc_next;
`endif
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard bench for fetch. The driver restarts an expected pc
// stream on every reset/redirect; the monitor pops it on each accepted
// instruction. A memory responder with variable latency checks bus protocol.
`timescale 1ns/1ps
module tb_fetch;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ack = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] instr, pc;
  logic        valid;

  logic        rst2 = 1'b1;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2 = 1'b0;
  logic [31:0] data2 = '0;
  logic [31:0] instr2, pc2;
  logic        valid2;

  fetch dut (
    .req(clk), .rst(rst), .stall_in(stall), .redirect_in(redirect),
    .redirect_pc_in(redirect_pc), .imem_req_out(imem_req), .imem_addr_out(imem_addr),
    .imem_ack_in(ack), .imem_data_in(data), .instr_out(instr), .pc_out(pc),
    .valid_out(valid)
  );

  fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .req(clk), .rst(rst2), .stall_in(1'b0), .redirect_in(1'b0),
    .redirect_pc_in(32'h0), .imem_req_out(req2), .imem_addr_out(addr2),
    .imem_ack_in(ack2), .imem_data_in(data2), .instr_out(instr2), .pc_out(pc2),
    .valid_out(valid2)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard -----------------
  logic [31:0] exp_pc_q[$];
  logic [31:0] wrap_q[$];

  task automatic start_stream(input logic [31:0] s);
    exp_pc_q.delete();
    for (int i = 0; i < 256; i++) exp_pc_q.push_back(s + 32'(4 * i));
  endtask

  // ---------------- memory responder -----------------
  int unsigned lat_mode = 0;      // 0: ack same cycle, 1: random 0..3 waits, 2: 3 waits
  logic        spurious_en = 1'b0;
  logic        late_ack_req = 1'b0;
  logic        late_ack_done = 1'b0;
  logic        mem_active = 1'b0;
  int unsigned mem_wait = 0;
  logic [31:0] mem_addr = '0;
  int unsigned mem_issues = 0;
  logic [31:0] last_req_addr = '0;

  always @(posedge clk) begin
    #2;
    if (ack && mem_active) mem_active = 1'b0;
    if (!imem_req) mem_active = 1'b0;
    if (imem_req) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_addr = imem_addr;
        mem_issues++;
        last_req_addr = imem_addr;
        mem_wait = (lat_mode == 0) ? 0 : (lat_mode == 1) ? $urandom_range(3, 0) : 3;
        check("req_align", 32'(imem_addr[1:0]), 32'd0);
      end else begin
        check("req_addr_stable", imem_addr, mem_addr);
      end
      if (mem_wait == 0) begin
        ack = 1'b1;
        data = mem_word(imem_addr);
      end else begin
        mem_wait--;
        ack = 1'b0;
        data = $urandom;
      end
    end else if (late_ack_req && !late_ack_done && !rst) begin
      ack = 1'b1;
      data = 32'hDEAD_BEEF;
      late_ack_done = 1'b1;
    end else if (spurious_en && $urandom_range(7, 0) == 0) begin
      ack = 1'b1;
      data = $urandom;
    end else begin
      ack = 1'b0;
    end
  end

  always @(posedge clk) begin
    #2;
    ack2 = req2;
    data2 = mem_word(addr2);
  end

  // ---------------- monitor -----------------
  int          occ = 0;
  logic        stale = 1'b0;
  logic        prev_rst = 1'b1;
  logic        hold = 1'b0;
  logic [31:0] hold_pc = '0, hold_instr = '0;
  int          pops = 0;
  int          wrap_pops = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    check("valid_vs_model", 32'(valid), 32'(occ > 0));
    if (!valid) begin
      check("idle_instr", instr, NOP);
      check("idle_pc", pc, 32'h0);
    end
    if (prev_rst) begin
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
    end
    if (hold) begin
      check("stall_pc", pc, hold_pc);
      check("stall_instr", instr, hold_instr);
    end
    hold = 1'b0;
    if (!rst && !redirect && valid) begin
      if (stall) begin
        hold = 1'b1;
        hold_pc = pc;
        hold_instr = instr;
      end else begin
        pops++;
        if (exp_pc_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL stream_underflow: got pc %h expected no output", pc);
        end else begin
          e = exp_pc_q.pop_front();
          check("pc_seq", pc, e);
          check("instr_seq", instr, mem_word(e));
        end
      end
    end
    // expected queue occupancy after the coming edge
    if (rst) begin
      occ = 0;
      stale = 1'b0;
    end else if (redirect) begin
      occ = 0;
      stale = imem_req & ~ack;
    end else begin
      if (imem_req && ack) begin
        if (stale) stale = 1'b0;
        else occ++;
      end
      if (valid && !stall && occ > 0) occ--;
    end
    check("occupancy_bound", 32'(occ <= DEPTH), 32'd1);
    prev_rst = rst;

    if (!rst2 && valid2) begin
      wrap_pops++;
      if (wrap_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wrap_underflow: got pc %h expected no output", pc2);
      end else begin
        e = wrap_q.pop_front();
        check("wrap_pc", pc2, e);
        check("wrap_instr", instr2, mem_word(e));
      end
    end
  end

  // ---------------- driver -----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    start_stream(32'h0);
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect = 1'b1;
    redirect_pc = t;
    start_stream(t & 32'hFFFF_FFFC);
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    int n;
    int p0;
    int unsigned iss0;
    logic [31:0] snap_pc, snap_instr;
    int r;

    start_stream(32'h0);
    wrap_q.push_back(32'hFFFF_FFF8);
    wrap_q.push_back(32'hFFFF_FFFC);
    wrap_q.push_back(32'h0000_0000);
    for (int i = 1; i <= 20; i++) wrap_q.push_back(32'(4 * i));
    repeat (3) tick();

    // back-to-back fetch from reset, plus the wrapping instance
    rst = 1'b0;
    rst2 = 1'b0;
    n = 0;
    while (!valid && n < 10) begin tick(); n++; end
    check("first_valid", 32'(valid), 32'd1);
    p0 = pops;
    repeat (10) tick();
    check("throughput", 32'(pops - p0), (DEPTH == 2) ? 32'd10 : 32'd5);
    repeat (6) tick();
    rst2 = 1'b1;
    check("wrap_progress", 32'(wrap_pops >= 3), 32'd1);

    // decode stall: outputs frozen, fetch stops once the queue is full
    stall = 1'b1;
    repeat (2) tick();
    snap_pc = pc;
    snap_instr = instr;
    iss0 = mem_issues;
    repeat (4) tick();
    check("stall_valid", 32'(valid), 32'd1);
    check("stall_hold_pc", pc, snap_pc);
    check("stall_hold_instr", instr, snap_instr);
    check("stall_no_issue", mem_issues - iss0, 32'd0);
    stall = 1'b0;

    // redirect while the request to 0x8 is pending
    lat_mode = 2;
    do_reset(2);
    n = 0;
    while (!(imem_req && imem_addr == 32'h8) && n < 80) begin tick(); n++; end
    check("req8_seen", 32'(imem_req && imem_addr == 32'h8), 32'd1);
    do_redirect(32'h103);
    iss0 = mem_issues;
    n = 0;
    while (mem_issues == iss0 && n < 20) begin tick(); n++; end
    check("redirect_req_addr", last_req_addr, 32'h100);
    n = 0;
    while (!valid && n < 20) begin tick(); n++; end
    check("redirect_first_pc", pc, 32'h100);
    repeat (4) tick();

    // redirect coincident with ack and pop
    lat_mode = 0;
    do_reset(2);
    n = 0;
    while (!((DEPTH == 2) ? (valid && imem_req) : imem_req) && n < 20) begin tick(); n++; end
    check("coincident_setup", 32'(imem_req), 32'd1);
    do_redirect(32'h200);
    check("flush_after_redirect", 32'(valid), 32'd0);
    repeat (10) tick();

    // reset with a request outstanding, stale ack after release
    lat_mode = 2;
    do_reset(2);
    n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    tick();
    rst = 1'b1;
    start_stream(32'h0);
    repeat (2) tick();
    rst = 1'b0;
    late_ack_req = 1'b1;
    tick();
    check("late_ack_driven", 32'(late_ack_done), 32'd1);
    repeat (15) tick();

    // randomized traffic
    lat_mode = 1;
    spurious_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(3, 0) == 0);
      r = $urandom_range(99, 0);
      if (r < 4) do_redirect($urandom);
      else if (r == 4) do_redirect(32'hFFFF_FFF0 + 32'($urandom_range(15, 0)));
      else if (r == 5) do_reset(2);
      else tick();
    end
    stall = 1'b0;
    repeat (5) tick();
    check("progress", 32'(pops > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset (word-aligned).
REQ-002 SHALL have port req, input, 1 bit: clock; all state updates on posedge req.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port stall_in, input, 1 bit: decode not accepting; driven by decode's rs_read.
REQ-005 SHALL have port redirect_in, input, 1 bit: taken branch/jump from execute.
REQ-006 SHALL have port redirect_pc_in, input, 32 bits: redirect target.
REQ-007 SHALL have port imem_req_out, output, 1 bit: instruction memory request.
REQ-008 SHALL have port imem_addr_out, output, 32 bits: request address.
REQ-009 SHALL have port imem_ack_in, input, 1 bit: memory response valid.
REQ-010 SHALL have port imem_data_in, input, 32 bits: instruction word, valid with imem_ack_in.
REQ-011 SHALL have port instr_out, output, 32 bits: instruction to decode instr_in.
REQ-012 SHALL have port pc_out, output, 32 bits: PC of instr_out, to decode pc_in_dec.
REQ-013 SHALL have port valid_out, output, 1 bit: instr_out/pc_out hold a real instruction.

Function
REQ-014 SHALL register imem_req_out and imem_addr_out, both changing only on a req edge.
REQ-015 SHALL hold imem_req_out=1 and imem_addr_out stable until imem_ack_in is sampled 1; one request outstanding at most.
REQ-016 SHALL treat imem_ack_in sampled while imem_req_out=0 as spurious and ignore it.
REQ-017 SHALL store {imem_data_in, imem_addr_out} into an instruction queue on the edge where ack is sampled; valid_out=1 from that edge onward.
REQ-018 SHALL issue a new request only when queue free entries exceed in-flight requests; fetch_pc advances by 4 on each issue, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-019 SHALL present the queue head combinationally on instr_out/pc_out; valid_out = queue not empty.
REQ-020 SHALL pop the head on an edge with valid_out=1 and stall_in=0; with stall_in=1, outputs SHALL stay unchanged.
REQ-021 SHALL allow push and pop on the same edge, including when the queue is full; count stays unchanged.
REQ-022 SHALL drive instr_out=32'h0000_0013 (NOP) and pc_out=32'h0 when valid_out=0.
REQ-023 On redirect_in=1: SHALL flush the queue (valid_out=0 on the next cycle) and set fetch_pc to {redirect_pc_in[31:2],2'b00}.
REQ-024 On redirect_in=1 with a request outstanding: SHALL keep that request until ack, discard its data, then request the redirect target.
REQ-025 Redirect and ack on the same edge: SHALL discard the ack data; redirect SHALL take priority over pop and push.
REQ-026 Redirect with no request outstanding: SHALL issue the target request on the next edge.

Reset
REQ-027 With rst=1 at an edge: fetch_pc=RESET_PC, queue empty, valid_out=0, imem_req_out=0, imem_addr_out=0, discard flag cleared.
REQ-028 First request SHALL assert on the first edge with rst=0; reset mid-request SHALL abandon it and ignore its later ack.

Configuration
REQ-029 Macro FETCH_PREFETCH_EN: defined -> queue depth 2 (fetch runs ahead during a stall); undefined -> depth 1 (single output register, next request only after pop).
REQ-030 Port list and all other behaviour SHALL be identical in both builds.

Verification
REQ-031 Reset release, memory acks every cycle -> first request at RESET_PC; pc_out sequence 0x0, 0x4, 0x8 with valid_out continuous, 1 fetch/cycle with FETCH_PREFETCH_EN defined.
REQ-032 stall_in=1 for 5 cycles, instr 0x00500093 at head -> outputs frozen; with FETCH_PREFETCH_EN defined, no requests beyond 2 queued; without it, no request beyond 1.
REQ-033 redirect_in=1, redirect_pc_in=0x103 while request to 0x8 pending and ack 3 cycles later -> 0x8 data dropped; next request at 0x100; next valid pc_out=0x100.
REQ-034 Redirect coincident with ack and pop -> queue empty the next cycle; no pc from the old stream appears afterward.
REQ-035 RESET_PC=0xFFFF_FFF8 -> pc_out sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-036 rst asserted with a request outstanding, ack arriving 1 cycle after rst falls -> ack ignored; fetch restarts at RESET_PC.
